mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Holds a word-addressed data memory split into
// byte lanes, performs byte/half/word stores, extracts and extends loads, and
// registers EX results into the WB-facing outputs.
//
// Ports
//   i_clk, i_reset          clock, async active-high reset (clears *_W only)
//   i_enable                pipeline advance; 0 freezes memory and *_W
//   i_alu_result_E          byte address / ALU result
//   i_operand_b_E           store data
//   i_instr_rd_E            destination register
//   i_branch_delay_slot_E   return address
//   i_*_MC                  control lines; i_bhw_MC = {unsigned, size[1:0]}
//   i_debug_addr            debug word address
//   o_*_W                   registered WB values
//   o_debug_mem_data        combinational memory word at i_debug_addr

// One byte lane of the data memory: sync write, async read on two ports.
module mem_byte_lane #(
    parameter int MEM_ADDR = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [MEM_ADDR-1:0] addr,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    input  logic [MEM_ADDR-1:0] dbg_addr,
    output logic [7:0]          dbg_data
);
    logic [7:0] mem [2**MEM_ADDR];

    // No reset: contents survive i_reset.
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata    = mem[addr];
    assign dbg_data = mem[dbg_addr];
endmodule

module mem_stage #(
    parameter int INST_SZ  = 32,
    parameter int MEM_ADDR = 8,
    parameter int BHW      = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [INST_SZ-1:0]  i_alu_result_E,
    input  logic [INST_SZ-1:0]  i_operand_b_E,
    input  logic [4:0]          i_instr_rd_E,
    input  logic [INST_SZ-1:0]  i_branch_delay_slot_E,
    input  logic                i_mem_read_MC,
    input  logic                i_mem_write_MC,
    input  logic                i_reg_write_MC,
    input  logic                i_mem_to_reg_MC,
    input  logic                i_jal_sel_MC,
    input  logic [BHW-1:0]      i_bhw_MC,
    input  logic [MEM_ADDR-1:0] i_debug_addr,
    output logic [INST_SZ-1:0]  o_read_data_W,
    output logic [INST_SZ-1:0]  o_alu_result_W,
    output logic [INST_SZ-1:0]  o_branch_delay_slot_W,
    output logic [4:0]          o_instr_rd_W,
    output logic                o_reg_write_W,
    output logic                o_mem_to_reg_W,
    output logic                o_jal_sel_W,
    output logic [INST_SZ-1:0]  o_debug_mem_data
);
    localparam int NUM_LANES = INST_SZ / 8;

    typedef struct packed {
        logic [INST_SZ-1:0] read_data;
        logic [INST_SZ-1:0] alu_result;
        logic [INST_SZ-1:0] bds;
        logic [4:0]         rd;
        logic               reg_write;
        logic               mem_to_reg;
        logic               jal_sel;
    } wb_t;

    logic [MEM_ADDR-1:0]        word_addr;
    logic [1:0]                 byte_off;
    logic                       is_word, is_half, is_uns;
    logic                       wr_en;
    logic [NUM_LANES-1:0]       lane_we;
    logic [NUM_LANES-1:0][7:0]  lane_wdata, lane_rdata, lane_ddata;
    logic [INST_SZ-1:0]         rword;
    logic [7:0]                 ld_b;
    logic [15:0]                ld_h;
    logic [INST_SZ-1:0]         load_ext;
    wb_t                        wb_d, wb_q;

    // Upper address bits are ignored, so the memory window wraps.
    assign word_addr = i_alu_result_E[MEM_ADDR+1:2];
    assign byte_off  = i_alu_result_E[1:0];
    assign is_word   = i_bhw_MC[1];
    assign is_half   = ~i_bhw_MC[1] & i_bhw_MC[0];
    assign is_uns    = i_bhw_MC[2];
    // A write coinciding with reset is dropped.
    assign wr_en     = i_enable & i_mem_write_MC & ~i_reset;

    always_comb begin
        lane_we = '0;
        if (is_word) begin
            lane_we = '1;
        end else if (is_half) begin
            lane_we[{byte_off[1], 1'b0}] = 1'b1;
            lane_we[{byte_off[1], 1'b1}] = 1'b1;
        end else begin
            lane_we[byte_off] = 1'b1;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        // Narrow stores replicate the low data bytes across lanes; lane_we picks.
        assign lane_wdata[l] = is_word ? i_operand_b_E[8*l +: 8] :
                               is_half ? i_operand_b_E[8*(l%2) +: 8] :
                                         i_operand_b_E[7:0];
        mem_byte_lane #(.MEM_ADDR(MEM_ADDR)) u_lane (
            .clk      (i_clk),
            .we       (wr_en & lane_we[l]),
            .addr     (word_addr),
            .wdata    (lane_wdata[l]),
            .rdata    (lane_rdata[l]),
            .dbg_addr (i_debug_addr),
            .dbg_data (lane_ddata[l])
        );
    end

    assign rword            = lane_rdata;
    assign o_debug_mem_data = lane_ddata;

    // Read path sees pre-edge contents, so read+write returns the old data.
    assign ld_b = rword[{byte_off, 3'b000} +: 8];
    assign ld_h = rword[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = rword;
        if (is_half)
            load_ext = {{(INST_SZ-16){ld_h[15] & ~is_uns}}, ld_h};
        else if (!is_word)
            load_ext = {{(INST_SZ-8){ld_b[7] & ~is_uns}}, ld_b};
    end

    always_comb begin
        wb_d            = '0;
        wb_d.read_data  = i_mem_read_MC ? load_ext : '0;
        wb_d.alu_result = i_alu_result_E;
        wb_d.bds        = i_branch_delay_slot_E;
        wb_d.rd         = i_instr_rd_E;
        wb_d.reg_write  = i_reg_write_MC;
        wb_d.mem_to_reg = i_mem_to_reg_MC;
        wb_d.jal_sel    = i_jal_sel_MC;
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset)       wb_q <= '0;
        else if (i_enable) wb_q <= wb_d;

    assign o_read_data_W         = wb_q.read_data;
    assign o_alu_result_W        = wb_q.alu_result;
    assign o_branch_delay_slot_W = wb_q.bds;
    assign o_instr_rd_W          = wb_q.rd;
    assign o_reg_write_W         = wb_q.reg_write;
    assign o_mem_to_reg_W        = wb_q.mem_to_reg;
    assign o_jal_sel_W           = wb_q.jal_sel;
endmodule
